// File: rtl/vga_pkg.sv
// vga_pkg: shared timing constants for 640x480@60, the colour-bar palette
// and the 24-bit pixel type used by the VGA display controller.
package vga_pkg;

    // Default 640x480@60 timing, in pixels (horizontal) and lines (vertical)
    localparam int VGA_H_SYNC  = 96;
    localparam int VGA_H_BACK  = 48;
    localparam int VGA_H_ACT   = 640;
    localparam int VGA_H_FRONT = 16;
    localparam int VGA_V_SYNC  = 2;
    localparam int VGA_V_BACK  = 33;
    localparam int VGA_V_ACT   = 480;
    localparam int VGA_V_FRONT = 10;

    // Counter width; 12 bits covers 800 columns and 525 lines with headroom
    localparam int CNT_W = 12;

    // Number of vertical colour bars in the test pattern
    localparam int BAR_COUNT = 8;

    // One pixel: {R[7:0], G[7:0], B[7:0]}
    typedef logic [23:0] pixel_t;

    // Colour bars, left to right
    typedef enum logic [2:0] {
        BAR_WHITE   = 3'd0,
        BAR_YELLOW  = 3'd1,
        BAR_CYAN    = 3'd2,
        BAR_GREEN   = 3'd3,
        BAR_MAGENTA = 3'd4,
        BAR_RED     = 3'd5,
        BAR_BLUE    = 3'd6,
        BAR_BLACK   = 3'd7
    } bar_e;

    localparam pixel_t COLOUR_WHITE   = 24'hFFFFFF;
    localparam pixel_t COLOUR_YELLOW  = 24'hFFFF00;
    localparam pixel_t COLOUR_CYAN    = 24'h00FFFF;
    localparam pixel_t COLOUR_GREEN   = 24'h00FF00;
    localparam pixel_t COLOUR_MAGENTA = 24'hFF00FF;
    localparam pixel_t COLOUR_RED     = 24'hFF0000;
    localparam pixel_t COLOUR_BLUE    = 24'h0000FF;
    localparam pixel_t COLOUR_BLACK   = 24'h000000;

    // Map a bar index to its full-scale colour
    function automatic pixel_t bar_colour(input bar_e bar);
        pixel_t colour;
        case (bar)
            BAR_WHITE:   colour = COLOUR_WHITE;
            BAR_YELLOW:  colour = COLOUR_YELLOW;
            BAR_CYAN:    colour = COLOUR_CYAN;
            BAR_GREEN:   colour = COLOUR_GREEN;
            BAR_MAGENTA: colour = COLOUR_MAGENTA;
            BAR_RED:     colour = COLOUR_RED;
            BAR_BLUE:    colour = COLOUR_BLUE;
            default:     colour = COLOUR_BLACK;
        endcase
        return colour;
    endfunction

endpackage

// File: rtl/vga_display_ctrl_if.sv
// vga_display_ctrl_if: bundles the read-FIFO handshake and the VGA video
// outputs of the display controller. The master modport is the controller
// itself; the slave modport is the FIFO / monitor side.
interface vga_display_ctrl_if;
    import vga_pkg::*;

    logic   rfifo_rd_ready;
    pixel_t rfifo_rd_data;
    logic   rfifo_rd_en;
    logic   vga_hsync;
    logic   vga_vsync;
    logic   vga_de;
    pixel_t vga_rgb;
    logic   frame_start;

    modport master (
        input  rfifo_rd_ready,
        input  rfifo_rd_data,
        output rfifo_rd_en,
        output vga_hsync,
        output vga_vsync,
        output vga_de,
        output vga_rgb,
        output frame_start
    );

    modport slave (
        output rfifo_rd_ready,
        output rfifo_rd_data,
        input  rfifo_rd_en,
        input  vga_hsync,
        input  vga_vsync,
        input  vga_de,
        input  vga_rgb,
        input  frame_start
    );

endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running horizontal/vertical counters and the
// combinational region decodes derived from them (sync, active, pre-active,
// first cycle of frame). Each line and frame runs sync, back porch, active,
// front porch starting at count 0.
// Build option: VGA_TEST_PATTERN_EN adds the colour-bar column decode.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_SYNC  = VGA_H_SYNC,
    parameter int H_BACK  = VGA_H_BACK,
    parameter int H_ACT   = VGA_H_ACT,
    parameter int H_FRONT = VGA_H_FRONT,
    parameter int V_SYNC  = VGA_V_SYNC,
    parameter int V_BACK  = VGA_V_BACK,
    parameter int V_ACT   = VGA_V_ACT,
    parameter int V_FRONT = VGA_V_FRONT
) (
    input  logic sclk,
    input  logic s_rst_n,
    output logic hsync_n_o,
    output logic vsync_n_o,
    output logic active_o,
    output logic pre_active_o,
`ifdef VGA_TEST_PATTERN_EN
    output bar_e bar_o,
`endif
    output logic frame_first_o
);

    localparam int H_TOT = H_SYNC + H_BACK + H_ACT + H_FRONT;
    localparam int V_TOT = V_SYNC + V_BACK + V_ACT + V_FRONT;
    localparam int H_AS  = H_SYNC + H_BACK;
    localparam int V_AS  = V_SYNC + V_BACK;

    localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_SYNC_END  = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] V_SYNC_END  = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] H_ACT_FIRST = CNT_W'(H_AS);
    localparam logic [CNT_W-1:0] H_ACT_END   = CNT_W'(H_AS + H_ACT);
    localparam logic [CNT_W-1:0] V_ACT_FIRST = CNT_W'(V_AS);
    localparam logic [CNT_W-1:0] V_ACT_END   = CNT_W'(V_AS + V_ACT);
    // The FIFO answers one cycle after a pop, so popping runs one column
    // ahead of the active window
    localparam logic [CNT_W-1:0] H_PRE_FIRST = CNT_W'(H_AS - 1);
    localparam logic [CNT_W-1:0] H_PRE_END   = CNT_W'(H_AS + H_ACT - 1);

    logic [CNT_W-1:0] h_cnt_q;
    logic [CNT_W-1:0] h_cnt_d;
    logic [CNT_W-1:0] v_cnt_q;
    logic [CNT_W-1:0] v_cnt_d;
    logic             h_active;
    logic             v_active;
    logic             h_pre;

    // Next counter values: h wraps every line, v advances on each h wrap
    always_comb begin
        h_cnt_d = h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d = '0;
            end else begin
                v_cnt_d = v_cnt_q + 1'b1;
            end
        end
    end

    // Counter registers; reset parks both at the first cycle of a frame
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    assign h_active = (h_cnt_q >= H_ACT_FIRST) && (h_cnt_q < H_ACT_END);
    assign v_active = (v_cnt_q >= V_ACT_FIRST) && (v_cnt_q < V_ACT_END);
    assign h_pre    = (h_cnt_q >= H_PRE_FIRST) && (h_cnt_q < H_PRE_END);

    assign hsync_n_o     = (h_cnt_q >= H_SYNC_END);
    assign vsync_n_o     = (v_cnt_q >= V_SYNC_END);
    assign active_o      = h_active && v_active;
    assign pre_active_o  = h_pre && v_active;
    assign frame_first_o = (h_cnt_q == '0) && (v_cnt_q == '0);

`ifdef VGA_TEST_PATTERN_EN
    localparam int BAR_W = H_ACT / BAR_COUNT;

    // Which colour bar the current column falls in (only meaningful while active)
    always_comb begin
        bar_o = BAR_WHITE;
        for (int i = 1; i < BAR_COUNT; i++) begin
            if (h_cnt_q >= CNT_W'(H_AS + i * BAR_W)) begin
                bar_o = bar_e'(3'(i));
            end
        end
    end
`endif

endmodule

// File: rtl/vga_display_ctrl.sv
// vga_display_ctrl: drives a VGA monitor from an SDRAM read FIFO. A frame is
// streamed only if the FIFO reported ready at the first cycle of that frame;
// the decision is then held for the whole frame. All video outputs are
// registered one cycle behind the counters.
// Build option: VGA_TEST_PATTERN_EN shows colour bars in frames without data.
module vga_display_ctrl
    import vga_pkg::*;
#(
    parameter int H_SYNC  = VGA_H_SYNC,
    parameter int H_BACK  = VGA_H_BACK,
    parameter int H_ACT   = VGA_H_ACT,
    parameter int H_FRONT = VGA_H_FRONT,
    parameter int V_SYNC  = VGA_V_SYNC,
    parameter int V_BACK  = VGA_V_BACK,
    parameter int V_ACT   = VGA_V_ACT,
    parameter int V_FRONT = VGA_V_FRONT
) (
    input logic                sclk,
    input logic                s_rst_n,
    vga_display_ctrl_if.master vga_bus
);

    logic   hsync_n;
    logic   vsync_n;
    logic   active;
    logic   pre_active;
    logic   frame_first;
    logic   run_q;
    logic   run_d;
    logic   hsync_q;
    logic   vsync_q;
    logic   de_q;
    logic   frame_start_q;
    pixel_t rgb_q;
    pixel_t rgb_d;
`ifdef VGA_TEST_PATTERN_EN
    bar_e   bar;
`endif

    vga_timing_gen #(
        .H_SYNC  (H_SYNC),
        .H_BACK  (H_BACK),
        .H_ACT   (H_ACT),
        .H_FRONT (H_FRONT),
        .V_SYNC  (V_SYNC),
        .V_BACK  (V_BACK),
        .V_ACT   (V_ACT),
        .V_FRONT (V_FRONT)
    ) u_timing (
        .sclk          (sclk),
        .s_rst_n       (s_rst_n),
        .hsync_n_o     (hsync_n),
        .vsync_n_o     (vsync_n),
        .active_o      (active),
        .pre_active_o  (pre_active),
`ifdef VGA_TEST_PATTERN_EN
        .bar_o         (bar),
`endif
        .frame_first_o (frame_first)
    );

    // Latch the FIFO's readiness once per frame, at its very first cycle
    assign run_d = frame_first ? vga_bus.rfifo_rd_ready : run_q;

    // Pop one word per active pixel, one column early to cover FIFO latency
    assign vga_bus.rfifo_rd_en = run_q && pre_active;

    // Pixel source: FIFO data while streaming, pattern or black otherwise
    always_comb begin
        rgb_d = '0;
        if (active) begin
            if (run_q) begin
                rgb_d = vga_bus.rfifo_rd_data;
            end
`ifdef VGA_TEST_PATTERN_EN
            else begin
                rgb_d = bar_colour(bar);
            end
`endif
        end
    end

    // Run flag and video output registers, all cleared to idle-monitor levels on reset
    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            run_q         <= 1'b0;
            hsync_q       <= 1'b1;
            vsync_q       <= 1'b1;
            de_q          <= 1'b0;
            frame_start_q <= 1'b0;
            rgb_q         <= '0;
        end else begin
            run_q         <= run_d;
            hsync_q       <= hsync_n;
            vsync_q       <= vsync_n;
            de_q          <= active;
            frame_start_q <= frame_first;
            rgb_q         <= rgb_d;
        end
    end

    assign vga_bus.vga_hsync   = hsync_q;
    assign vga_bus.vga_vsync   = vsync_q;
    assign vga_bus.vga_de      = de_q;
    assign vga_bus.vga_rgb     = rgb_q;
    assign vga_bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_display_ctrl.sv
// tb_vga_display_ctrl: directed bench for vga_display_ctrl using a reduced
// timing (25 x 13 cycles per frame) so several frames fit in a short run.
// A FIFO model hands out an incrementing count; every delivered word is queued
// and must reappear on vga_rgb in order, one per vga_de cycle of a run frame.
// Build option: VGA_TEST_PATTERN_EN switches expected idle pixels to bars.
`timescale 1ns/1ps
module tb_vga_display_ctrl;
    import vga_pkg::*;

    localparam int HS = 4;
    localparam int HB = 3;
    localparam int HA = 16;
    localparam int HF = 2;
    localparam int VS = 2;
    localparam int VB = 3;
    localparam int VA = 6;
    localparam int VF = 2;
    localparam int HT = HS + HB + HA + HF;
    localparam int VT = VS + VB + VA + VF;
    localparam int HAS = HS + HB;
    localparam int VAS = VS + VB;
    localparam int FRAME_POPS = HA * VA;
    localparam int BARW = HA / 8;
    localparam int FRAME_BUDGET = 2 * HT * VT;

`ifdef VGA_TEST_PATTERN_EN
    localparam logic [31:0] IDLE_FIRST_PIX = 32'hFFFFFF;
    localparam logic [31:0] IDLE_BAR1_PIX  = 32'hFFFF00;
`else
    localparam logic [31:0] IDLE_FIRST_PIX = 32'h000000;
    localparam logic [31:0] IDLE_BAR1_PIX  = 32'h000000;
`endif

    logic sclk = 1'b0;
    logic s_rst_n = 1'b0;

    vga_display_ctrl_if vga_bus();

    vga_display_ctrl #(
        .H_SYNC (HS), .H_BACK (HB), .H_ACT (HA), .H_FRONT (HF),
        .V_SYNC (VS), .V_BACK (VB), .V_ACT (VA), .V_FRONT (VF)
    ) dut (
        .sclk    (sclk),
        .s_rst_n (s_rst_n),
        .vga_bus (vga_bus)
    );

    always #5 sclk = ~sclk;

    int checks = 0;
    int errors = 0;

    int mh, mv;
    bit mrun;
    bit popPending = 1'b0;
    pixel_t expQ[$];
    int unsigned fifoWord = 0;

    int frameCnt = 0;
    int curPops = 0, curDe = 0, curHsLow = 0, curVsLow = 0;
    int lastPops = 0, lastDe = 0, lastHsLow = 0, lastVsLow = 0;
    logic [23:0] curFirst = '0, curLast = '0, curBar = '0;
    logic [23:0] lastFirst = '0, lastLast = '0, lastBar = '0;
    int cyc = 0, lastHsFall = -1, lastVsFall = -1, hsPeriod = 0, vsPeriod = 0;
    logic prevHs = 1'b1, prevVs = 1'b1;

    // One comparison: counts it, and on mismatch counts and reports the failure
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive the bench-controlled inputs
    task automatic applyStimulus(input logic ready, input logic rstN);
        vga_bus.rfifo_rd_ready = ready;
        s_rst_n = rstN;
    endtask

    task automatic stepCycles(input int n);
        repeat (n) begin
            @(negedge sclk);
            #2;
        end
    endtask

    task automatic waitFrameStart(input string tag);
        int start;
        start = frameCnt;
        for (int i = 0; i < FRAME_BUDGET; i++) begin
            stepCycles(1);
            if (frameCnt != start) break;
        end
        checkOutput(tag, frameCnt, start + 1);
    endtask

    task automatic waitPos(input string tag, input int h, input int v);
        bit found;
        found = 1'b0;
        for (int i = 0; i < FRAME_BUDGET; i++) begin
            stepCycles(1);
            if (mh == h && mv == v) begin
                found = 1'b1;
                break;
            end
        end
        checkOutput(tag, found, 1);
    endtask

    function automatic logic [31:0] barExp(input int h);
`ifdef VGA_TEST_PATTERN_EN
        logic [31:0] c;
        case ((h - HAS) / BARW)
            0: c = 32'hFFFFFF;
            1: c = 32'hFFFF00;
            2: c = 32'h00FFFF;
            3: c = 32'h00FF00;
            4: c = 32'hFF00FF;
            5: c = 32'hFF0000;
            6: c = 32'h0000FF;
            default: c = 32'h000000;
        endcase
        return c;
`else
        return (h < 0) ? 32'h1 : 32'h0;
`endif
    endfunction

    // FIFO model: one cycle after a pop, present the next count and queue it
    initial begin
        vga_bus.rfifo_rd_data = '0;
        forever begin
            @(posedge sclk);
            #1;
            if (popPending && s_rst_n) begin
                vga_bus.rfifo_rd_data = pixel_t'(fifoWord);
                expQ.push_back(pixel_t'(fifoWord));
                fifoWord++;
            end else begin
                vga_bus.rfifo_rd_data = pixel_t'($urandom);
            end
        end
    end

    // Per-cycle monitor: reference timing model, scoreboard and frame statistics
    initial begin
        int ph, pv;
        bit prun, act;
        logic [31:0] expRgb;
        mh = 0; mv = 0; mrun = 1'b0;
        forever begin
            @(negedge sclk);
            popPending = vga_bus.rfifo_rd_en;
            cyc++;
            if (!s_rst_n) begin
                mh = 0; mv = 0; mrun = 1'b0;
                expQ.delete();
                curPops = 0; curDe = 0; curHsLow = 0; curVsLow = 0;
                lastHsFall = -1; lastVsFall = -1;
                checkOutput("rst_hsync", vga_bus.vga_hsync, 1);
                checkOutput("rst_vsync", vga_bus.vga_vsync, 1);
                checkOutput("rst_de", vga_bus.vga_de, 0);
                checkOutput("rst_rgb", vga_bus.vga_rgb, 0);
                checkOutput("rst_frame_start", vga_bus.frame_start, 0);
            end else begin
                ph = mh; pv = mv; prun = mrun;
                act = (ph >= HAS) && (ph < HAS + HA) && (pv >= VAS) && (pv < VAS + VA);
                checkOutput("hsync", vga_bus.vga_hsync, (ph >= HS));
                checkOutput("vsync", vga_bus.vga_vsync, (pv >= VS));
                checkOutput("de", vga_bus.vga_de, act);
                checkOutput("frame_start", vga_bus.frame_start, (ph == 0 && pv == 0));
                if (act && prun) begin
                    expRgb = (expQ.size() > 0) ? {8'h00, expQ.pop_front()} : 32'hFFFFFFFF;
                end else if (act) begin
                    expRgb = barExp(ph);
                end else begin
                    expRgb = 32'h0;
                end
                checkOutput("rgb", vga_bus.vga_rgb, expRgb);
                if (ph == 0 && pv == 0) mrun = vga_bus.rfifo_rd_ready;
                mh = ph + 1;
                if (mh == HT) begin
                    mh = 0;
                    mv = (pv + 1 == VT) ? 0 : pv + 1;
                end
            end
            checkOutput("rd_en", vga_bus.rfifo_rd_en,
                        s_rst_n && mrun && (mv >= VAS) && (mv < VAS + VA) &&
                        (mh >= HAS - 1) && (mh < HAS + HA - 1));

            if (s_rst_n && prevHs && !vga_bus.vga_hsync) begin
                if (lastHsFall >= 0) hsPeriod = cyc - lastHsFall;
                lastHsFall = cyc;
            end
            if (s_rst_n && prevVs && !vga_bus.vga_vsync) begin
                if (lastVsFall >= 0) vsPeriod = cyc - lastVsFall;
                lastVsFall = cyc;
            end
            prevHs = vga_bus.vga_hsync;
            prevVs = vga_bus.vga_vsync;

            if (vga_bus.frame_start) begin
                lastPops = curPops; lastDe = curDe; lastHsLow = curHsLow; lastVsLow = curVsLow;
                lastFirst = curFirst; lastLast = curLast; lastBar = curBar;
                curPops = 0; curDe = 0; curHsLow = 0; curVsLow = 0;
                frameCnt++;
            end
            if (s_rst_n) begin
                curPops += int'(vga_bus.rfifo_rd_en);
                curHsLow += int'(!vga_bus.vga_hsync);
                curVsLow += int'(!vga_bus.vga_vsync);
                if (vga_bus.vga_de) begin
                    if (curDe == 0) curFirst = vga_bus.vga_rgb;
                    if (curDe == BARW) curBar = vga_bus.vga_rgb;
                    curLast = vga_bus.vga_rgb;
                    curDe++;
                end
            end
        end
    end

    // Watchdog so the run always ends
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence
    initial begin
        int firstPopCyc;
        bit popSeen;

        // Reset with the FIFO ready so the first frame streams
        applyStimulus(1'b1, 1'b0);
        stepCycles(3);
        checkOutput("reset_hsync", vga_bus.vga_hsync, 1);
        checkOutput("reset_vsync", vga_bus.vga_vsync, 1);
        checkOutput("reset_de", vga_bus.vga_de, 0);
        checkOutput("reset_rgb", vga_bus.vga_rgb, 0);
        checkOutput("reset_frame_start", vga_bus.frame_start, 0);
        checkOutput("reset_rd_en", vga_bus.rfifo_rd_en, 0);

        applyStimulus(1'b1, 1'b1);
        stepCycles(1);
        checkOutput("fs_after_release", vga_bus.frame_start, 1);

        // Frame 0: ready throughout
        waitFrameStart("frame0_end");
        $display("[TB] frame 0 done: pops %0d", lastPops);
        checkOutput("frame0_pops", lastPops, FRAME_POPS);
        checkOutput("frame0_de", lastDe, FRAME_POPS);
        checkOutput("frame0_hs_low", lastHsLow, HS * VT);
        checkOutput("frame0_vs_low", lastVsLow, VS * HT);
        checkOutput("hsync_period", hsPeriod, HT);
        checkOutput("vsync_period", vsPeriod, HT * VT);
        checkOutput("frame0_first_pix", lastFirst, 0);
        checkOutput("frame0_last_pix", lastLast, FRAME_POPS - 1);

        // Frame 1: ready drops mid-frame, frame must still complete
        waitPos("drop_pos", 0, VAS + 2);
        applyStimulus(1'b0, 1'b1);
        waitFrameStart("frame1_end");
        checkOutput("drop_frame_pops", lastPops, FRAME_POPS);
        checkOutput("drop_frame_last_pix", lastLast, 2 * FRAME_POPS - 1);

        // Frame 2: not ready at frame start, no pops but full active area
        waitFrameStart("frame2_end");
        checkOutput("idle_pops", lastPops, 0);
        checkOutput("idle_de", lastDe, FRAME_POPS);
        checkOutput("idle_first_pix", lastFirst, IDLE_FIRST_PIX);
        checkOutput("idle_bar1_pix", lastBar, IDLE_BAR1_PIX);

        // Frame 3: ready rises mid-frame, streaming starts only in frame 4
        waitPos("rise_pos", 0, VAS + 2);
        applyStimulus(1'b1, 1'b1);
        waitFrameStart("frame3_end");
        checkOutput("rise_frame_pops", lastPops, 0);
        waitFrameStart("frame4_end");
        checkOutput("rise_next_pops", lastPops, FRAME_POPS);
        checkOutput("rise_next_first_pix", lastFirst, 2 * FRAME_POPS);

        // Frame 5: reset in the middle of an active line
        waitPos("reset_pos", 10, VAS + 2);
        checkOutput("pre_reset_de", vga_bus.vga_de, 1);
        applyStimulus(1'b1, 1'b0);
        #1;
        checkOutput("midrst_hsync", vga_bus.vga_hsync, 1);
        checkOutput("midrst_vsync", vga_bus.vga_vsync, 1);
        checkOutput("midrst_de", vga_bus.vga_de, 0);
        checkOutput("midrst_rgb", vga_bus.vga_rgb, 0);
        checkOutput("midrst_frame_start", vga_bus.frame_start, 0);
        checkOutput("midrst_rd_en", vga_bus.rfifo_rd_en, 0);
        stepCycles(3);
        applyStimulus(1'b1, 1'b1);
        stepCycles(1);
        checkOutput("fs_after_midrst", vga_bus.frame_start, 1);

        firstPopCyc = 1;
        popSeen = 1'b0;
        for (int i = 0; i < FRAME_BUDGET; i++) begin
            if (vga_bus.rfifo_rd_en) begin
                popSeen = 1'b1;
                break;
            end
            stepCycles(1);
            firstPopCyc++;
        end
        checkOutput("first_pop_seen", popSeen, 1);
        checkOutput("first_pop_cycle", firstPopCyc, VAS * HT + HAS - 1);
        waitFrameStart("post_reset_frame_end");
        checkOutput("post_reset_pops", lastPops, FRAME_POPS);

        stepCycles(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_display_ctrl.md
VGA_DISPLAY_CTRL -- requirements
Module: vga_display_ctrl

Interface
REQ-001 Parameters, one per line: H_SYNC 96, horizontal sync width in pixels; H_BACK 48, horizontal back porch; H_ACT 640, active pixels per line; H_FRONT 16, horizontal front porch; V_SYNC 2, vertical sync lines; V_BACK 33, vertical back porch; V_ACT 480, active lines; V_FRONT 10, vertical front porch.
REQ-002 Ports SHALL be (name, direction, width, meaning):
- sclk, in, 1: pixel clock; the same clock as rfifo_rclk of the SDRAM controller.
- s_rst_n, in, 1: reset, asynchronous, active-low.
- rfifo_rd_ready, in, 1: read FIFO holds enough data for a frame.
- rfifo_rd_data, in, 24: read FIFO data, valid one cycle after rfifo_rd_en.
- rfifo_rd_en, out, 1: read FIFO pop.
- vga_hsync, out, 1: horizontal sync, active-low.
- vga_vsync, out, 1: vertical sync, active-low.
- vga_de, out, 1: active-video qualifier.
- vga_rgb, out, 24: pixel {R[7:0], G[7:0], B[7:0]}.
- frame_start, out, 1: one-cycle pulse on the first cycle of each frame.

Function
REQ-003 H_TOT = H_SYNC+H_BACK+H_ACT+H_FRONT and V_TOT likewise; counters are h_cnt 0..H_TOT-1 and v_cnt 0..V_TOT-1.
REQ-004 h_cnt SHALL increment every cycle and wrap to 0 after H_TOT-1.
REQ-005 v_cnt SHALL increment when h_cnt wraps, and wrap to 0 after V_TOT-1.
REQ-006 Each line and frame SHALL be ordered sync, back porch, active, front porch, starting at count 0.
REQ-007 Active region: H_AS = H_SYNC+H_BACK <= h_cnt < H_AS+H_ACT, and V_AS = V_SYNC+V_BACK <= v_cnt < V_AS+V_ACT.
REQ-008 The internal flag run SHALL be sampled from rfifo_rd_ready only at h_cnt=0, v_cnt=0, and SHALL be held for the whole frame.
REQ-009 rfifo_rd_en SHALL be a combinational output = run AND v_cnt active AND H_AS-1 <= h_cnt < H_AS+H_ACT-1, giving exactly H_ACT pops per active line and H_ACT*V_ACT pops per frame.
REQ-010 A falling rfifo_rd_ready mid-frame SHALL NOT stop popping; the frame completes.
REQ-011 All video outputs SHALL be registered, so output at cycle t+1 reflects the counters at cycle t.
- vga_hsync = 0 iff h_cnt < H_SYNC.
- vga_vsync = 0 iff v_cnt < V_SYNC.
- vga_de = 1 iff the counters are in the active region.
- vga_rgb = rfifo_rd_data when active and run, otherwise 24'h000000.
REQ-012 frame_start SHALL be registered high for one cycle following h_cnt=0, v_cnt=0, independent of run.
REQ-013 vga_rgb, vga_de and the sync signals SHALL be mutually aligned; the first pixel of a line appears with the first vga_de=1 cycle.

Reset
REQ-014 While s_rst_n=0: h_cnt=0, v_cnt=0, run=0; outputs vga_hsync=1, vga_vsync=1, vga_de=0, vga_rgb=0, frame_start=0; rfifo_rd_en=0.
REQ-015 After reset release, the first counted cycle is h_cnt=0, v_cnt=0, and frame_start follows one cycle later.
REQ-016 Reset asserted mid-frame SHALL abort the frame immediately; no FIFO pops occur until the next frame with run=1.

Configuration
REQ-017 Macro VGA_TEST_PATTERN_EN:
- Defined: in active cycles with run=0, vga_rgb SHALL be 8 vertical colour bars, each H_ACT/8 wide, in the order white, yellow, cyan, green, magenta, red, blue, black (full-scale 8'hFF components).
- Not defined: those cycles output 24'h000000.
- Pop behaviour is identical either way.

Structure
REQ-018 A shared package vga_pkg SHALL hold the 640x480@60 timing constants, the colour-bar constants and a 24-bit pixel typedef.
REQ-019 One sub-module, vga_timing_gen, SHALL hold the counters and the region decodes (sync, active, pre-active); vga_display_ctrl holds run, the FIFO pop logic and the output registers.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
- rfifo_rd_ready=1 constantly, FIFO model returns an incrementing count -> 307200 pops per frame; line 0 vga_rgb reads 0..639; hsync period 800 cycles, low for 96; vsync period 420000 cycles, low for 1600.
- rfifo_rd_ready=0 through a full frame -> zero pops; vga_de still asserted for 640x480 pixels; rgb=0 (macro undefined) or bars with first pixel FFFFFF and pixel 80 FFFF00 (macro defined).
- rfifo_rd_ready rises at v_cnt=100 -> no pops in that frame; pops start at the next frame.
- rfifo_rd_ready falls at v_cnt=200 with run=1 -> all 307200 pops still occur in that frame.
- Reset asserted at h_cnt=400, v_cnt=300 -> outputs take reset values immediately; after release, frame_start is seen 1 cycle later and the first pop at the 143rd cycle of line 35.
- Alignment check -> in every cycle with vga_de=1, vga_rgb equals the FIFO word popped exactly one cycle earlier.
